trng_health_monitor: RTL and testbench

- Online health tester that sits directly downstream of the TRNG entropy extractor and consumes its raw sampled bit stream, one bit per valid cycle.
- Runs two continuous tests on every bit:
  - a Repetition Count Test (RCT), which detects stuck or long-run output;
  - an Adaptive Proportion Test (APT), which detects bias within a window.
- Bits pass downstream only after a clean start-up window and only while no failure is present.
- Any failure latches a sticky alarm that software must clear explicitly.

---
 rtl/trng_pkg.sv | 19 +
 rtl/trng_apt_counter.sv | 57 +++++
 rtl/trng_health_monitor.sv | 135 +++++++++++++
 tb/tb_trng_health_monitor.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/trng_pkg.sv
// Shared types and helpers for the TRNG health monitor.
// FSM state encoding and a constant clog2.
package trng_pkg;

  typedef enum logic [1:0] {
    STARTUP = 2'd0,
    RUN     = 2'd1,
    ALARM   = 2'd2
  } state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/trng_apt_counter.sv
// Adaptive proportion test: window index, reference bit and match count.
// Flags when the updated match count reaches the cutoff.
module trng_apt_counter
  import trng_pkg::*;
#(
  parameter int APT_WINDOW = 1024,
  parameter int APT_CUTOFF = 600
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sample,
  input  logic valid,
  input  logic restart,
  output logic fail,
  output logic window_end
);

  localparam int IW = clog2(APT_WINDOW);
  localparam int MW = clog2(APT_CUTOFF + 1);
  localparam logic [IW-1:0] I_LAST = IW'(APT_WINDOW - 1);
  localparam logic [MW-1:0] M_MAX  = MW'(APT_CUTOFF);

  logic [IW-1:0] idx_q;
  logic [MW-1:0] match_q;
  logic [MW-1:0] match_d;
  logic          ref_q;

  // Updated match count for the current sample.
  always_comb begin
    match_d = match_q;
    if (idx_q == '0)
      match_d = MW'(1);
    else if (sample == ref_q && match_q != M_MAX)
      match_d = match_q + MW'(1);
  end

  assign fail       = valid & ~restart & (match_d == M_MAX);
  assign window_end = valid & ~restart & (idx_q == I_LAST);

  // Window state advances only on accepted samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q   <= '0;
      match_q <= '0;
      ref_q   <= 1'b0;
    end else if (restart) begin
      idx_q   <= '0;
      match_q <= '0;
      ref_q   <= 1'b0;
    end else if (valid) begin
      idx_q   <= idx_q + IW'(1);
      match_q <= match_d;
      if (idx_q == '0) ref_q <= sample;
    end
  end

endmodule

// File: rtl/trng_health_monitor.sv
// Online RCT/APT health tester for the raw TRNG bit stream.
// Forwards bits only in RUN; any failure latches a sticky alarm.
module trng_health_monitor
  import trng_pkg::*;
#(
  parameter int RCT_CUTOFF = 32,
  parameter int APT_WINDOW = 1024,
  parameter int APT_CUTOFF = 600
) (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_rnd,
  input  logic i_rnd_valid,
  input  logic i_alarm_clr,
  output logic o_rnd,
  output logic o_rnd_valid,
  output logic o_healthy,
  output logic o_rct_fail,
  output logic o_apt_fail,
  output logic o_alarm
);

  localparam int RW = clog2(RCT_CUTOFF + 1);
  localparam logic [RW-1:0] R_MAX = RW'(RCT_CUTOFF);

  logic [1:0]    rst_sync;
  logic          rst_n;
  state_t        state_q, state_d;
  logic [RW-1:0] run_q, run_d;
  logic          last_q;
  logic          rct_fail, apt_fail, fail_any;
  logic          window_end, restart;
  logic          rct_d, apt_d;

  // Asynchronous assert, synchronous release of the internal reset.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) rst_sync <= 2'b00;
    else            rst_sync <= {rst_sync[0], 1'b1};
  end

  assign rst_n   = rst_sync[1];
  assign restart = (state_q == ALARM) & i_alarm_clr;

  // Run length after this sample; a zero run means no previous bit.
  always_comb begin
    run_d = RW'(1);
    if (run_q != '0 && i_rnd == last_q)
      run_d = (run_q == R_MAX) ? run_q : run_q + RW'(1);
  end

  assign rct_fail = i_rnd_valid & ~restart & (run_d == R_MAX);
  assign fail_any = rct_fail | apt_fail;

  trng_apt_counter #(
    .APT_WINDOW (APT_WINDOW),
    .APT_CUTOFF (APT_CUTOFF)
  ) u_apt (
    .clk        (i_clk),
    .rst_n      (rst_n),
    .sample     (i_rnd),
    .valid      (i_rnd_valid),
    .restart    (restart),
    .fail       (apt_fail),
    .window_end (window_end)
  );

  // Repetition count state; a clear forgets the last bit.
  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q  <= '0;
      last_q <= 1'b0;
    end else if (restart) begin
      run_q  <= '0;
      last_q <= 1'b0;
    end else if (i_rnd_valid) begin
      run_q  <= run_d;
      last_q <= i_rnd;
    end
  end

  // Next state and sticky flag updates.
  always_comb begin
    state_d = state_q;
    rct_d   = o_rct_fail;
    apt_d   = o_apt_fail;
    unique case (state_q)
      STARTUP: begin
        if (fail_any) begin
          state_d = ALARM;
          rct_d   = o_rct_fail | rct_fail;
          apt_d   = o_apt_fail | apt_fail;
        end else if (window_end) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (fail_any) begin
          state_d = ALARM;
          rct_d   = o_rct_fail | rct_fail;
          apt_d   = o_apt_fail | apt_fail;
        end
      end
      ALARM: begin
        if (i_alarm_clr) begin
          state_d = STARTUP;
          rct_d   = 1'b0;
          apt_d   = 1'b0;
        end
      end
      default: state_d = STARTUP;
    endcase
  end

  // State, flags and the one-cycle output path.
  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= STARTUP;
      o_rct_fail  <= 1'b0;
      o_apt_fail  <= 1'b0;
      o_alarm     <= 1'b0;
      o_healthy   <= 1'b0;
      o_rnd       <= 1'b0;
      o_rnd_valid <= 1'b0;
    end else begin
      state_q     <= state_d;
      o_rct_fail  <= rct_d;
      o_apt_fail  <= apt_d;
      o_alarm     <= rct_d | apt_d;
      o_healthy   <= (state_d == RUN);
      o_rnd_valid <= i_rnd_valid & (state_q == RUN) & ~fail_any;
      if (i_rnd_valid) o_rnd <= i_rnd;
    end
  end

endmodule

// File: tb/tb_trng_health_monitor.sv
// Directed self-checking bench for trng_health_monitor.
// Small parameters: RCT_CUTOFF=4, APT_WINDOW=16, APT_CUTOFF=12.
module tb_trng_health_monitor;

  logic clk;
  logic rst_n;
  logic rnd, rnd_valid, alarm_clr;
  logic o_rnd, o_rnd_valid, o_healthy;
  logic o_rct_fail, o_apt_fail, o_alarm;

  int checks;
  int errors;

  trng_health_monitor #(
    .RCT_CUTOFF (4),
    .APT_WINDOW (16),
    .APT_CUTOFF (12)
  ) dut (
    .i_clk       (clk),
    .i_reset_n   (rst_n),
    .i_rnd       (rnd),
    .i_rnd_valid (rnd_valid),
    .i_alarm_clr (alarm_clr),
    .o_rnd       (o_rnd),
    .o_rnd_valid (o_rnd_valid),
    .o_healthy   (o_healthy),
    .o_rct_fail  (o_rct_fail),
    .o_apt_fail  (o_apt_fail),
    .o_alarm     (o_alarm)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    rst_n = 1'b0;
    rnd_valid = 1'b0;
    alarm_clr = 1'b0;
    rnd = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic b);
    rnd = b;
    rnd_valid = 1'b1;
    @(posedge clk);
    #1 rnd_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    rnd_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // 16 alternating samples 0,1,...,1 completing one APT window.
  task automatic startup();
    for (int i = 0; i < 16; i++) send(logic'(i % 2));
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    rnd_valid = 1'b0;
    alarm_clr = 1'b0;
    rnd = 1'b0;
    #1;
    checks++;
    if ({o_rnd, o_rnd_valid, o_healthy, o_rct_fail, o_apt_fail, o_alarm}
        !== 6'b0) begin
      errors++;
      $display("FAIL reset_outputs got %b exp 000000",
        {o_rnd, o_rnd_valid, o_healthy, o_rct_fail, o_apt_fail, o_alarm});
    end
    do_reset();
    checks++;
    if (o_healthy !== 1'b0 || o_alarm !== 1'b0) begin
      errors++;
      $display("FAIL reset_release healthy %b alarm %b exp 0 0",
        o_healthy, o_alarm);
    end
  endtask

  task automatic test_startup();
    do_reset();
    for (int i = 0; i < 15; i++) send(logic'(i % 2));
    checks++;
    if (o_healthy !== 1'b0) begin
      errors++;
      $display("FAIL startup_early got %b exp 0", o_healthy);
    end
    send(1'b1);
    checks++;
    if (o_healthy !== 1'b1 || o_rnd_valid !== 1'b0) begin
      errors++;
      $display("FAIL startup_16 healthy %b vld %b exp 1 0",
        o_healthy, o_rnd_valid);
    end
    send(1'b0);
    checks++;
    if (o_rnd_valid !== 1'b1 || o_rnd !== 1'b0) begin
      errors++;
      $display("FAIL startup_fwd vld %b rnd %b exp 1 0",
        o_rnd_valid, o_rnd);
    end
    send(1'b1);
    checks++;
    if (o_rnd_valid !== 1'b1 || o_rnd !== 1'b1) begin
      errors++;
      $display("FAIL startup_fwd2 vld %b rnd %b exp 1 1",
        o_rnd_valid, o_rnd);
    end
    checks++;
    if ({o_rct_fail, o_apt_fail, o_alarm} !== 3'b000) begin
      errors++;
      $display("FAIL startup_flags got %b exp 000",
        {o_rct_fail, o_apt_fail, o_alarm});
    end
  endtask

  task automatic test_rct();
    do_reset();
    startup();
    send(1'b0);
    send(1'b1);
    send(1'b1);
    send(1'b1);
    checks++;
    if (o_rct_fail !== 1'b0 || o_rnd_valid !== 1'b1) begin
      errors++;
      $display("FAIL rct_third fail %b vld %b exp 0 1",
        o_rct_fail, o_rnd_valid);
    end
    send(1'b1);
    checks++;
    if ({o_rct_fail, o_apt_fail, o_alarm} !== 3'b101) begin
      errors++;
      $display("FAIL rct_flags got %b exp 101",
        {o_rct_fail, o_apt_fail, o_alarm});
    end
    checks++;
    if (o_rnd_valid !== 1'b0 || o_healthy !== 1'b0) begin
      errors++;
      $display("FAIL rct_block vld %b healthy %b exp 0 0",
        o_rnd_valid, o_healthy);
    end
  endtask

  // Window 0001 0001 0001 000: the 12th zero lands on index 14.
  task automatic test_apt();
    logic [15:0] pat;
    do_reset();
    startup();
    pat = 16'b1000_1000_1000_1000;
    for (int i = 0; i < 14; i++) send(pat[i]);
    checks++;
    if (o_apt_fail !== 1'b0 || o_rnd_valid !== 1'b1) begin
      errors++;
      $display("FAIL apt_before fail %b vld %b exp 0 1",
        o_apt_fail, o_rnd_valid);
    end
    send(pat[14]);
    checks++;
    if ({o_rct_fail, o_apt_fail, o_alarm} !== 3'b011) begin
      errors++;
      $display("FAIL apt_flags got %b exp 011",
        {o_rct_fail, o_apt_fail, o_alarm});
    end
    checks++;
    if (o_rnd_valid !== 1'b0 || o_healthy !== 1'b0) begin
      errors++;
      $display("FAIL apt_block vld %b healthy %b exp 0 0",
        o_rnd_valid, o_healthy);
    end
  endtask

  // Runs from the ALARM left by test_apt.
  task automatic test_clear();
    rnd = 1'b1;
    rnd_valid = 1'b1;
    alarm_clr = 1'b1;
    @(posedge clk);
    #1 rnd_valid = 1'b0;
    alarm_clr = 1'b0;
    checks++;
    if ({o_rct_fail, o_apt_fail, o_alarm, o_healthy, o_rnd_valid}
        !== 5'b0) begin
      errors++;
      $display("FAIL clear_outputs got %b exp 00000",
        {o_rct_fail, o_apt_fail, o_alarm, o_healthy, o_rnd_valid});
    end
    for (int i = 0; i < 15; i++) send(logic'(i % 2));
    checks++;
    if (o_healthy !== 1'b0) begin
      errors++;
      $display("FAIL clear_discard got %b exp 0", o_healthy);
    end
    send(1'b1);
    checks++;
    if (o_healthy !== 1'b1) begin
      errors++;
      $display("FAIL clear_restart got %b exp 1", o_healthy);
    end
    alarm_clr = 1'b1;
    @(posedge clk);
    #1 alarm_clr = 1'b0;
    checks++;
    if (o_healthy !== 1'b1 || o_alarm !== 1'b0) begin
      errors++;
      $display("FAIL clear_in_run healthy %b alarm %b exp 1 0",
        o_healthy, o_alarm);
    end
    send(1'b0);
    checks++;
    if (o_rnd_valid !== 1'b1 || o_rnd !== 1'b0) begin
      errors++;
      $display("FAIL clear_fwd vld %b rnd %b exp 1 0",
        o_rnd_valid, o_rnd);
    end
  endtask

  task automatic test_gap();
    do_reset();
    startup();
    send(1'b0);
    send(1'b0);
    for (int i = 0; i < 5; i++) begin
      idle(1);
      checks++;
      if (o_rnd_valid !== 1'b0) begin
        errors++;
        $display("FAIL gap_vld cycle %0d got %b exp 0", i, o_rnd_valid);
      end
    end
    send(1'b0);
    checks++;
    if (o_rct_fail !== 1'b0 || o_rnd_valid !== 1'b1) begin
      errors++;
      $display("FAIL gap_third fail %b vld %b exp 0 1",
        o_rct_fail, o_rnd_valid);
    end
    send(1'b0);
    checks++;
    if (o_rct_fail !== 1'b1 || o_alarm !== 1'b1) begin
      errors++;
      $display("FAIL gap_rct fail %b alarm %b exp 1 1",
        o_rct_fail, o_alarm);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    startup();
    send(1'b0);
    send(1'b1);
    checks++;
    if (o_rnd_valid !== 1'b1 || o_rnd !== 1'b1 || o_healthy !== 1'b1) begin
      errors++;
      $display("FAIL areset_pre vld %b rnd %b healthy %b exp 1 1 1",
        o_rnd_valid, o_rnd, o_healthy);
    end
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if ({o_rnd, o_rnd_valid, o_healthy, o_rct_fail, o_apt_fail, o_alarm}
        !== 6'b0) begin
      errors++;
      $display("FAIL areset_async got %b exp 000000",
        {o_rnd, o_rnd_valid, o_healthy, o_rct_fail, o_apt_fail, o_alarm});
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 15; i++) send(logic'(i % 2));
    checks++;
    if (o_healthy !== 1'b0) begin
      errors++;
      $display("FAIL areset_early got %b exp 0", o_healthy);
    end
    send(1'b1);
    checks++;
    if (o_healthy !== 1'b1) begin
      errors++;
      $display("FAIL areset_run got %b exp 1", o_healthy);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_startup();
    test_rct();
    test_apt();
    test_clear();
    test_gap();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
